// File: rtl/jsilicon_pkg.sv
// jsilicon_pkg: shared opcode encoding, serializer state codes and UART frame constants.
package jsilicon_pkg;
   typedef enum logic [2:0] {
      OP_ADD = 3'd0,
      OP_SUB = 3'd1,
      OP_MUL = 3'd2,
      OP_AND = 3'd3,
      OP_OR  = 3'd4,
      OP_XOR = 3'd5,
      OP_SHL = 3'd6,
      OP_CMP = 3'd7
   } op_e;
   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
   localparam logic [2:0] ST_PARITY = 3'd3;
   localparam logic [2:0] ST_STOP   = 3'd4;
   localparam int UART_DATA_BITS = 8;
endpackage

// File: rtl/uart_tx_core.sv
// uart_tx_core: byte-wide UART transmitter, 8N1 or 8E1 when UART_PARITY_EN is defined.
//   clk, rst_n : clock, asynchronous active-low reset
//   load, data : a byte is offered while load is high; take pulses in the cycle it is consumed
//   tx, busy   : serial line (idle high) and "not IDLE"
// A byte offered during the last STOP cycle starts its START bit on the very next cycle.
module uart_tx_core
   import jsilicon_pkg::*;
#(
   parameter int CLK_DIV = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic [7:0] data,
   output logic       take,
   output logic       tx,
   output logic       busy
);
   localparam int DW = $clog2(CLK_DIV);
   logic [2:0]    state;
   logic [DW-1:0] div;
   logic [2:0]    bitc;
   logic [7:0]    sh;
   logic          tick;
   assign tick = div == DW'(CLK_DIV - 1);
   assign take = load && (state == ST_IDLE || (state == ST_STOP && tick));
   assign busy = state != ST_IDLE;
`ifdef UART_PARITY_EN
   logic par;
   assign tx = state == ST_START ? 1'b0 : state == ST_DATA ? sh[0] : state == ST_PARITY ? par : 1'b1;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) par <= 1'b0;
      else if (take) par <= ^data;
`else
   assign tx = state == ST_START ? 1'b0 : state == ST_DATA ? sh[0] : 1'b1;
`endif
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         div   <= '0;
         bitc  <= '0;
         sh    <= '0;
      end else if (take) begin
         state <= ST_START;
         div   <= '0;
         sh    <= data;
      end else if (state != ST_IDLE) begin
         div <= tick ? '0 : div + 1'b1;
         if (tick)
            case (state)
               ST_START: begin
                  state <= ST_DATA;
                  bitc  <= '0;
               end
               ST_DATA: begin
                  sh   <= sh >> 1;
                  bitc <= bitc + 1'b1;
`ifdef UART_PARITY_EN
                  if (bitc == 3'(UART_DATA_BITS - 1)) state <= ST_PARITY;
`else
                  if (bitc == 3'(UART_DATA_BITS - 1)) state <= ST_STOP;
`endif
               end
               ST_PARITY: state <= ST_STOP;
               default:   state <= ST_IDLE;
            endcase
      end
   end
endmodule

// File: rtl/alu_uart_engine.sv
// alu_uart_engine: one-cycle ALU feeding a result FIFO that is streamed LSB-byte-first over UART.
//   clk, rst_n          : clock, asynchronous active-low reset
//   start, a, b, opcode : request, accepted when start && ready
//   ready               : FIFO not full (registered)
//   result, result_valid: last result (held), one-cycle pulse the cycle after accept
//   drop_err            : sticky, a start arrived while !ready
//   tx, tx_busy         : UART line and serializer activity
// Optional feature: define UART_PARITY_EN for even parity (8E1) frames.
module alu_uart_engine
   import jsilicon_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int CLK_DIV    = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [DATA_W-1:0]   a,
   input  logic [DATA_W-1:0]   b,
   input  logic [2:0]          opcode,
   output logic                ready,
   output logic [2*DATA_W-1:0] result,
   output logic                result_valid,
   output logic                drop_err,
   output logic                tx,
   output logic                tx_busy
);
   localparam int RES_W = 2 * DATA_W;
   localparam int NB    = RES_W / 8;
   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam int SW    = $clog2(RES_W);
   logic             accept, pop, have, take;
   logic [RES_W-1:0] ax, bx, alu, cur;
   logic [RES_W-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]    wp, rp;
   logic [AW:0]      cnt, cnt_n;
   logic [2:0]       left;
   assign accept = start && ready;
   assign ax     = RES_W'(a);
   assign bx     = RES_W'(b);
   always_comb begin
      case (op_e'(opcode))
         OP_ADD:  alu = ax + bx;
         OP_SUB:  alu = ax - bx;
         OP_MUL:  alu = ax * bx;
         OP_AND:  alu = ax & bx;
         OP_OR:   alu = ax | bx;
         OP_XOR:  alu = ax ^ bx;
         OP_SHL:  alu = ax << b[SW-1:0];
         default: alu = RES_W'({a > b, a == b, a < b});
      endcase
   end
   // The serializer drains the bytes of the result it holds before popping the next one.
   assign have  = left != 3'd0;
   assign pop   = take && !have;
   assign cnt_n = cnt + (AW+1)'(accept) - (AW+1)'(pop);
   uart_tx_core #(.CLK_DIV(CLK_DIV)) u_tx (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (have || cnt != '0),
      .data  (have ? cur[7:0] : mem[rp][7:0]),
      .take  (take),
      .tx    (tx),
      .busy  (tx_busy)
   );
   always_ff @(posedge clk)
      if (accept) mem[wp] <= alu;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result       <= '0;
         result_valid <= 1'b0;
         drop_err     <= 1'b0;
         ready        <= 1'b1;
         cnt          <= '0;
         wp           <= '0;
         rp           <= '0;
         cur          <= '0;
         left         <= '0;
      end else begin
         result_valid <= accept;
         if (accept) result <= alu;
         drop_err <= drop_err | (start & ~ready);
         wp       <= wp + AW'(accept);
         rp       <= rp + AW'(pop);
         cnt      <= cnt_n;
         ready    <= cnt_n != (AW+1)'(FIFO_DEPTH);
         if (take) begin
            cur  <= have ? cur >> 8 : mem[rp] >> 8;
            left <= have ? left - 3'd1 : 3'(NB - 1);
         end
      end
   end
endmodule

// File: tb/tb_alu_uart_engine.sv
// tb_alu_uart_engine: scoreboard bench; stimulus queues expected results and UART bytes, monitors check them.
module tb_alu_uart_engine;
   localparam int CD = 16;
`ifdef UART_PARITY_EN
   localparam int FB = 11;
`else
   localparam int FB = 10;
`endif
   typedef struct {
      logic [15:0] r;
      int          c;
   } exp_t;
   logic        clk, rst_n, start, ready, result_valid, drop_err, tx, tx_busy;
   logic [7:0]  a, b;
   logic [2:0]  opcode;
   logic [15:0] result;
   logic        start1, ready1, rv1, de1, tx1, busy1;
   logic [3:0]  a1, b1;
   logic [7:0]  result1;
   int          n_chk, n_fail, cyc;
   bit          mon_en;
   exp_t        res_q[$];
   logic [7:0]  byte_q[$];

   alu_uart_engine #(.DATA_W(8), .CLK_DIV(CD), .FIFO_DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .opcode(opcode), .ready(ready),
      .result(result), .result_valid(result_valid), .drop_err(drop_err), .tx(tx), .tx_busy(tx_busy)
   );
   alu_uart_engine #(.DATA_W(4), .CLK_DIV(2), .FIFO_DEPTH(4)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .opcode(3'd0), .ready(ready1),
      .result(result1), .result_valid(rv1), .drop_err(de1), .tx(tx1), .tx_busy(busy1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic send(input logic [2:0] op, input logic [7:0] av, input logic [7:0] bv,
                       input logic [15:0] r, input bit acc, input bit bytes_exp);
      @(negedge clk);
      start = 1'b1; a = av; b = bv; opcode = op;
      check("ready_at_start", ready, acc);
      if (acc) begin
         res_q.push_back('{r, cyc + 1});
         if (bytes_exp) begin
            byte_q.push_back(r[7:0]);
            byte_q.push_back(r[15:8]);
         end
      end
   endtask

   task automatic idle();
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic drain();
      for (int k = 0; k < 5000 && (byte_q.size() != 0 || tx_busy); k++) @(negedge clk);
      repeat (3) @(negedge clk);
      check("drain_bytes_left", byte_q.size(), 0);
      check("drain_results_left", res_q.size(), 0);
      check("drain_tx_idle", {tx_busy, tx}, 2'b01);
   endtask

   always @(negedge clk)
      if (result_valid === 1'b1) begin
         if (res_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_result: got %0h with nothing queued", result);
         end else begin
            exp_t e;
            e = res_q.pop_front();
            check("result_value", result, e.r);
            check("result_latency", cyc, e.c);
         end
      end

   initial begin : uart_mon
      logic [10:0] fr;
      bit          bad, cont;
      logic [7:0]  eb;
      cont = 1'b0;
      @(negedge clk);
      forever begin
         if (!cont) while (tx !== 1'b0) @(negedge clk);
         bad = 1'b0;
         fr  = '0;
         for (int i = 0; i < FB; i++)
            for (int j = 0; j < CD; j++) begin
               if (i != 0 || j != 0) @(negedge clk);
               if (j == 0) fr[i] = tx;
               else if (tx !== fr[i]) bad = 1'b1;
               if (tx_busy !== 1'b1) bad = 1'b1;
            end
         if (mon_en) begin
            check("bit_timing", bad, 0);
            check("start_bit", fr[0], 0);
            check("stop_bit", fr[FB-1], 1);
`ifdef UART_PARITY_EN
            check("parity_bit", fr[9], ^fr[8:1]);
`endif
            if (byte_q.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_byte: got %0h with nothing queued", fr[8:1]);
            end else begin
               eb = byte_q.pop_front();
               check("tx_byte", fr[8:1], eb);
            end
         end
         @(negedge clk);
         cont = tx_busy;
         if (cont && mon_en) check("no_idle_gap", tx, 0);
      end
   end

   initial begin
      logic [10:0] ef;
      logic [1:0]  s;
      int          lows;
      n_chk = 0; n_fail = 0; cyc = 0; mon_en = 1'b1;
      rst_n = 1'b0; start = 1'b0; a = '0; b = '0; opcode = '0;
      start1 = 1'b0; a1 = '0; b1 = '0;
      repeat (2) @(negedge clk);
      check("rst_result", result, 16'h0000);
      check("rst_result_valid", result_valid, 0);
      check("rst_drop_err", drop_err, 0);
      check("rst_tx", tx, 1);
      check("rst_tx_busy", tx_busy, 0);
      check("rst_ready", ready, 1);
      rst_n = 1'b1;
      // ADD with carry into bit 8
      send(3'd0, 8'hFF, 8'h01, 16'h0100, 1, 1);
      idle();
      drain();
      // MUL, SUB, CMP equal back to back
      send(3'd2, 8'hFF, 8'hFF, 16'hFE01, 1, 1);
      send(3'd1, 8'h01, 8'h02, 16'hFFFF, 1, 1);
      send(3'd7, 8'h03, 8'h03, 16'h0002, 1, 1);
      idle();
      drain();
      // AND, OR, SHL, XOR
      send(3'd3, 8'hF0, 8'h3C, 16'h0030, 1, 1);
      send(3'd4, 8'hF0, 8'h0F, 16'h00FF, 1, 1);
      send(3'd6, 8'h01, 8'h09, 16'h0200, 1, 1);
      send(3'd5, 8'h0F, 8'h00, 16'h000F, 1, 1);
      idle();
      drain();
      // occupy the serializer, then overflow the FIFO
      send(3'd7, 8'h05, 8'h03, 16'h0004, 1, 1);
      idle();
      repeat (2) @(negedge clk);
      send(3'd0, 8'h10, 8'h20, 16'h0030, 1, 1);
      send(3'd1, 8'h00, 8'h01, 16'hFFFF, 1, 1);
      send(3'd2, 8'h12, 8'h34, 16'h03A8, 1, 1);
      send(3'd5, 8'hAA, 8'h55, 16'h00FF, 1, 1);
      send(3'd0, 8'h77, 8'h11, 16'h0088, 0, 1);
      idle();
      check("drop_err_set", drop_err, 1);
      check("result_held_after_drop", result, 16'h00FF);
      check("ready_low_when_full", ready, 0);
      drain();
      check("ready_after_drain", ready, 1);
      // narrow instance: 4-bit operands, 2 clocks per bit
      @(negedge clk);
      start1 = 1'b1; a1 = 4'hF; b1 = 4'hF;
      @(negedge clk);
      start1 = 1'b0;
      check("u1_result_valid", rv1, 1);
      check("u1_result", result1, 8'h1E);
`ifdef UART_PARITY_EN
      ef = {1'b1, 1'b0, 8'h1E, 1'b0};
`else
      ef = {1'b0, 1'b1, 8'h1E, 1'b0};
`endif
      for (int k = 0; k < 20 && tx1 !== 1'b0; k++) @(negedge clk);
      check("u1_start_seen", tx1, 0);
      for (int i = 0; i < FB; i++) begin
         for (int j = 0; j < 2; j++) begin
            if (i != 0 || j != 0) @(negedge clk);
            s[j] = tx1;
         end
         check("u1_bit", s, {ef[i], ef[i]});
      end
      @(negedge clk);
      check("u1_idle_after_frame", {busy1, tx1}, 2'b01);
      // reset in the middle of data bit 3 of byte 0 (0x30, bit 3 = 0)
      mon_en = 1'b0;
      send(3'd0, 8'h10, 8'h20, 16'h0030, 1, 0);
      idle();
      for (int k = 0; k < 20 && tx_busy !== 1'b1; k++) @(negedge clk);
      repeat (4 * CD + CD / 2) @(negedge clk);
      check("pre_rst_busy", tx_busy, 1);
      check("pre_rst_tx_bit3", tx, 0);
      rst_n = 1'b0;
      #1;
      check("async_rst_tx", tx, 1);
      check("async_rst_busy", tx_busy, 0);
      check("async_rst_ready", ready, 1);
      check("async_rst_drop_err", drop_err, 0);
      check("async_rst_result", result, 16'h0000);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      lows = 0;
      for (int k = 0; k < 400; k++) begin
         @(negedge clk);
         if (tx !== 1'b1 || tx_busy !== 1'b0) lows++;
      end
      check("no_frame_after_rst", lows, 0);
      check("results_consumed", res_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
